// File: rtl/udp_tx_scheduler.sv
// Round-robin owner of the shared UDP TX mux: one datagram per grant,
// with a watchdog that revokes a source that stops making progress.
module udp_tx_scheduler #(
  parameter int S_COUNT = 3,
  parameter int TIMEOUT = 65535,
  localparam int SEL_W = $clog2(S_COUNT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [S_COUNT-1:0] req,
  input  logic [S_COUNT-1:0] req_mask,
  input  logic               hdr_valid,
  input  logic               hdr_ready,
  input  logic               tvalid,
  input  logic               tready,
  input  logic               tlast,
  output logic [SEL_W-1:0]   select,
  output logic               enable,
  output logic [S_COUNT-1:0] grant,
  output logic               busy,
  output logic               timeout_pulse,
  output logic [15:0]        timeout_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W:0] S_CNT = (SEL_W+1)'(S_COUNT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, win, ptr_nxt;
  logic [S_COUNT-1:0] elig, win_oh;
  logic [SEL_W:0]     cand, inc;
  logic [WD_W-1:0]    wd, wd_inc;
  logic               found;
  logic               hs_hdr, hs_pay, beat;
  logic               expire, done;

  assign elig   = req & req_mask;
  assign hs_hdr = hdr_valid & hdr_ready;
  assign hs_pay = tvalid & tready;
  assign beat   = hs_hdr | hs_pay;
  assign wd_inc = wd + WD_W'(1);
  assign busy   = (state != IDLE);

  // first eligible index at or after ptr, wrapping
  always_comb begin
    win    = '0;
    win_oh = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(i);
      if (cand >= S_CNT) cand = cand - S_CNT;
      if (!found && elig[cand[SEL_W-1:0]]) begin
        found = 1'b1;
        win   = cand[SEL_W-1:0];
      end
    end
    if (found) win_oh[win] = 1'b1;
  end

  always_comb begin
    inc     = {1'b0, select} + (SEL_W+1)'(1);
    ptr_nxt = (inc == S_CNT) ? '0 : inc[SEL_W-1:0];
  end

  // a handshake in the expiring cycle keeps the grant alive
  assign expire = busy && !beat && (wd_inc == WD_MAX);
  assign done   = (state == PAY && hs_pay && tlast) || expire;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (found) state_nxt = HDR;
      HDR: begin
        if (hs_hdr) state_nxt = PAY;
        else if (expire) state_nxt = IDLE;
      end
      PAY: begin
        if (hs_pay && tlast) state_nxt = IDLE;
        else if (expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      wd            <= '0;
      select        <= '0;
      enable        <= 1'b0;
      grant         <= '0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      wd            <= (state == IDLE || beat) ? '0 : wd_inc;
      timeout_pulse <= expire;
      if (expire && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
      if (state == IDLE && found) begin
        select <= win;
        grant  <= win_oh;
        enable <= 1'b1;
      end else if (done) begin
        grant  <= '0;
        enable <= 1'b0;
        ptr    <= ptr_nxt;
      end
    end
  end

endmodule
